rambam_sbox_sched: RTL

Scheduler that time-multiplexes one pipelined RAMBAM masked S-box across the 16 bytes of an AES state. It accepts a full masked state, issues one byte per cycle to the shared S-box together with fresh randomness from the PRNG, and collects the S-box outputs in order into a result buffer. It sits between the round controller and the `rambam_sbox_storage` datapath, and is the only driver of the S-box inputs.

---
 rtl/rambam_sbox_sched_if.sv | 40 ++++
 rtl/rambam_sbox_sched.sv | 113 +++++++++++
 2 files changed

// File: rtl/rambam_sbox_sched_if.sv
// rtl/rambam_sbox_sched_if.sv - handshake and S-box bus bundle for the RAMBAM S-box scheduler
//
// Purpose: groups every non-clock, non-reset signal of rambam_sbox_sched.
// Ports (W = 8+D):
//   start_valid/start_ready/state_in[NBYTES*W]  state hand-off from the round controller
//   rnd_in[7*D]/rnd_valid/rnd_ready             fresh randomness from the PRNG
//   sb_in[W]/sb_r[7*D]/sb_out[W]                shared pipelined masked S-box
//   state_out[NBYTES*W]/out_valid/out_ready     substituted state to the consumer
//   busy                                        scheduler not idle
// The slave modport is the scheduler; the master modport is its environment.
interface rambam_sbox_sched_if #(
  parameter int D      = 4,
  parameter int NBYTES = 16
);
  localparam int W = 8 + D;

  logic                start_valid;
  logic                start_ready;
  logic [NBYTES*W-1:0] state_in;
  logic [7*D-1:0]      rnd_in;
  logic                rnd_valid;
  logic                rnd_ready;
  logic [W-1:0]        sb_in;
  logic [7*D-1:0]      sb_r;
  logic [W-1:0]        sb_out;
  logic [NBYTES*W-1:0] state_out;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  start_valid, state_in, rnd_in, rnd_valid, sb_out, out_ready,
    output start_ready, rnd_ready, sb_in, sb_r, state_out, out_valid, busy
  );

  modport master (
    output start_valid, state_in, rnd_in, rnd_valid, sb_out, out_ready,
    input  start_ready, rnd_ready, sb_in, sb_r, state_out, out_valid, busy
  );
endinterface

// File: rtl/rambam_sbox_sched.sv
// rtl/rambam_sbox_sched.sv - time-multiplexes one pipelined masked S-box over an AES state
//
// Purpose: latches a masked state, issues one byte per randomness handshake to the
// shared S-box, and collects the S-box results in issue order into state_out.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   rambam_sbox_sched_if.slave (start/rnd/S-box/output handshakes, busy)
module rambam_sbox_sched #(
  parameter int D        = 4,
  parameter int SBOX_LAT = 4,
  parameter int NBYTES   = 16
) (
  input  logic               clk,
  input  logic               rst,
  rambam_sbox_sched_if.slave bus
);
  localparam int W  = 8 + D;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          fsm_q;
  logic [CW-1:0]       issue_cnt;
  logic [CW-1:0]       coll_cnt;
  logic [SBOX_LAT:0]   tag_q;
  logic [NBYTES*W-1:0] st_q;
  logic [NBYTES*W-1:0] res_q;
  logic [W-1:0]        sb_in_q;
  logic [7*D-1:0]      sb_r_q;
  logic [IW-1:0]       issue_idx;
  logic [IW-1:0]       coll_idx;
  logic                issue_hs;
  logic                capture;

  // Counters never exceed NBYTES-1 while used as an index.
  assign issue_idx = issue_cnt[IW-1:0];
  assign coll_idx  = coll_cnt[IW-1:0];

  assign issue_hs = (fsm_q == S_ISSUE) && bus.rnd_valid;
  // A tag leaves the pipeline exactly when its byte's result sits on sb_out.
  assign capture  = tag_q[SBOX_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q     <= S_IDLE;
      issue_cnt <= '0;
      coll_cnt  <= '0;
      tag_q     <= '0;
      st_q      <= '0;
      res_q     <= '0;
      sb_in_q   <= '0;
      sb_r_q    <= '0;
    end else begin
      tag_q <= {tag_q[SBOX_LAT-1:0], issue_hs};

      // Zero the S-box inputs on every non-issue cycle so no stale
      // masked data lingers on the shared datapath.
      sb_in_q <= issue_hs ? st_q[issue_idx*W +: W] : '0;
      sb_r_q  <= issue_hs ? bus.rnd_in : '0;

      if (issue_hs) begin
        issue_cnt <= issue_cnt + CW'(1);
      end

      if (capture) begin
        res_q[coll_idx*W +: W] <= bus.sb_out;
        coll_cnt               <= coll_cnt + CW'(1);
      end

      case (fsm_q)
        S_IDLE: begin
          if (bus.start_valid) begin
            st_q      <= bus.state_in;
            issue_cnt <= '0;
            coll_cnt  <= '0;
            fsm_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_hs && (issue_cnt == LAST)) begin
            fsm_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Enter DONE on the same edge that captures the last byte.
          if (capture && (coll_cnt == LAST)) begin
            fsm_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            fsm_q <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (fsm_q == S_IDLE);
  assign bus.rnd_ready   = (fsm_q == S_ISSUE);
  assign bus.out_valid   = (fsm_q == S_DONE);
  assign bus.busy        = (fsm_q != S_IDLE);
  assign bus.sb_in       = sb_in_q;
  assign bus.sb_r        = sb_r_q;
  assign bus.state_out   = res_q;
endmodule
